// File: rtl/ram_upload_server_if.sv
// hps_io upload-direction signals shared between the HPS side and the RAM upload server.
// The master modport is the HPS end and the slave modport is the server end.
interface ram_upload_server_if;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        ioctl_upload_req;

    modport master (
        output ioctl_upload,
        output ioctl_index,
        output ioctl_rd,
        output ioctl_addr,
        input  ioctl_din,
        input  ioctl_wait,
        input  ioctl_upload_req
    );

    modport slave (
        input  ioctl_upload,
        input  ioctl_index,
        input  ioctl_rd,
        input  ioctl_addr,
        output ioctl_din,
        output ioctl_wait,
        output ioctl_upload_req
    );
endinterface

// File: rtl/ram_upload_server.sv
// Streams a window of work RAM to the HPS during an upload session, pausing the game CPU first.
// It can also request an upload on a save trigger, giving up after TIMEOUT cycles.
module ram_upload_server #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned BASE    = 32'h6100,
    parameter int unsigned LENGTH  = 256,
    parameter logic [7:0]  INDEX   = 8'd4,
    parameter int unsigned RAM_LAT = 1,
    parameter logic [23:0] TIMEOUT = 24'd4_000_000
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    ram_upload_server_if.slave  hps,
    input  logic                save_trigger,
    output logic                pause_req,
    input  logic                pause_ack,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic                ram_rd,
    input  logic [7:0]          ram_dout,
    output logic                done,
    output logic                timeout_err
);

    localparam logic [25:0]       LEN_EXT      = 26'(LENGTH);
    localparam logic [1:0]        LAT          = 2'(RAM_LAT);
    localparam logic [ADDR_W-1:0] BASE_A       = ADDR_W'(BASE);
    localparam logic [23:0]       TIMEOUT_LAST = TIMEOUT - 24'd1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        PAUSE,
        STREAM
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [23:0] tmo_cnt;
    logic        pending;
    logic [24:0] pend_addr;
    logic        busy;
    logic [1:0]  lat_cnt;
    logic        out_of_range;
    logic [7:0]  din_q;
    logic        wait_q;

    logic        session_match;
    logic        session_end;
    logic        tmo_hit;
    logic [24:0] rd_off;
    logic        in_range;
    logic        start;

    assign session_match = hps.ioctl_upload && (hps.ioctl_index == INDEX);
    assign session_end   = ((state == PAUSE) || (state == STREAM)) && !hps.ioctl_upload;
    assign tmo_hit       = (state == REQ) && !session_match && (tmo_cnt == TIMEOUT_LAST);
    assign rd_off        = pending ? pend_addr : hps.ioctl_addr;
    assign in_range      = ({1'b0, rd_off} < LEN_EXT);
    // A read latched while paused is replayed on the first STREAM cycle.
    assign start         = (state == STREAM) && hps.ioctl_upload && !busy &&
                           (pending || (hps.ioctl_rd && !wait_q));

    assign pause_req            = (state == PAUSE) || (state == STREAM);
    assign hps.ioctl_upload_req = (state == REQ);
    assign hps.ioctl_din        = din_q;
    assign hps.ioctl_wait       = wait_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (session_match) begin
                    state_nxt = PAUSE;
                end else if (save_trigger) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (session_match) begin
                    state_nxt = PAUSE;
                end else if (tmo_cnt == TIMEOUT_LAST) begin
                    state_nxt = IDLE;
                end
            end
            PAUSE: begin
                if (!hps.ioctl_upload) begin
                    state_nxt = IDLE;
                end else if (pause_ack) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (!hps.ioctl_upload) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read pipeline: issue strobe, count down the RAM latency, then capture and release wait.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt      <= '0;
            pending      <= 1'b0;
            pend_addr    <= '0;
            busy         <= 1'b0;
            lat_cnt      <= '0;
            out_of_range <= 1'b0;
            din_q        <= 8'hFF;
            wait_q       <= 1'b0;
            ram_addr     <= '0;
            ram_rd       <= 1'b0;
            done         <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            done        <= (state == STREAM) && !hps.ioctl_upload;
            timeout_err <= tmo_hit;
            tmo_cnt     <= (state == REQ) ? tmo_cnt + 24'd1 : '0;
            ram_rd      <= 1'b0;
            if (session_end) begin
                pending <= 1'b0;
                busy    <= 1'b0;
                wait_q  <= 1'b0;
            end else if ((state == PAUSE) && hps.ioctl_rd && !wait_q) begin
                pending   <= 1'b1;
                pend_addr <= hps.ioctl_addr;
                wait_q    <= 1'b1;
            end else if (start) begin
                pending      <= 1'b0;
                busy         <= 1'b1;
                wait_q       <= 1'b1;
                lat_cnt      <= LAT;
                out_of_range <= !in_range;
                if (in_range) begin
                    ram_rd   <= 1'b1;
                    ram_addr <= BASE_A + rd_off[ADDR_W-1:0];
                end
            end else if (busy) begin
                if (lat_cnt == 2'd0) begin
                    busy   <= 1'b0;
                    wait_q <= 1'b0;
                    din_q  <= out_of_range ? 8'hFF : ram_dout;
                end else begin
                    lat_cnt <= lat_cnt - 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_upload_server.sv
// Directed bench for ram_upload_server: expected bytes are queued when a read is issued
// and popped when the server drops ioctl_wait.
module tb_ram_upload_server;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        save_trigger;
    logic        pause_req;
    logic        pause_ack;
    logic [15:0] ram_addr;
    logic        ram_rd;
    logic [7:0]  ram_dout = 8'h00;
    logic        done;
    logic        timeout_err;

    int          pass_count  = 0;
    int          check_count = 0;
    int          ram_rd_cnt  = 0;
    int          done_cnt    = 0;
    logic [7:0]  exp_q[$];

    ram_upload_server_if hps ();

    ram_upload_server #(
        .ADDR_W (16),
        .BASE   (32'h6100),
        .LENGTH (256),
        .INDEX  (8'd4),
        .RAM_LAT(1),
        .TIMEOUT(24'd100)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .hps         (hps.slave),
        .save_trigger(save_trigger),
        .pause_req   (pause_req),
        .pause_ack   (pause_ack),
        .ram_addr    (ram_addr),
        .ram_rd      (ram_rd),
        .ram_dout    (ram_dout),
        .done        (done),
        .timeout_err (timeout_err)
    );

    always #5 clk_sys = ~clk_sys;

    // One-cycle-latency RAM holding i^5A at BASE+i; anything outside the window reads EE.
    always @(posedge clk_sys) begin
        if (ram_rd) begin
            if (ram_addr >= 16'h6100 && ram_addr <= 16'h61FF) begin
                ram_dout <= ram_addr[7:0] ^ 8'h5A;
            end else begin
                ram_dout <= 8'hEE;
            end
        end
    end

    always @(posedge clk_sys) begin
        if (ram_rd === 1'b1) ram_rd_cnt <= ram_rd_cnt + 1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 1ms");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count = check_count + 1;
        assert (observed === expected) pass_count = pass_count + 1;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic [24:0] offset, input logic [7:0] expected);
        @(negedge clk_sys);
        hps.ioctl_rd   = 1'b1;
        hps.ioctl_addr = offset;
        exp_q.push_back(expected);
        @(negedge clk_sys);
        hps.ioctl_rd   = 1'b0;
    endtask

    task automatic collectRead(input string tag, input int exp_waits);
        int waits = 0;
        logic [7:0] expected;
        while (hps.ioctl_wait === 1'b1 && waits < 64) begin
            waits = waits + 1;
            @(negedge clk_sys);
        end
        checkOutput({tag, "_wait"}, 32'(waits), 32'(exp_waits));
        if (exp_q.size() == 0) begin
            checkOutput({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            expected = exp_q.pop_front();
            checkOutput({tag, "_byte"}, {24'd0, hps.ioctl_din}, {24'd0, expected});
        end
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) @(negedge clk_sys);
    endtask

    initial begin
        int rd_snap;
        int done_snap;
        int hi;
        int n;

        reset_n          = 1'b0;
        save_trigger     = 1'b0;
        pause_ack        = 1'b0;
        hps.ioctl_upload = 1'b0;
        hps.ioctl_index  = 8'd0;
        hps.ioctl_rd     = 1'b0;
        hps.ioctl_addr   = '0;

        idleCycles(2);
        checkOutput("rst_din", {24'd0, hps.ioctl_din}, 32'hFF);
        checkOutput("rst_wait", {31'd0, hps.ioctl_wait}, 32'd0);
        checkOutput("rst_upload_req", {31'd0, hps.ioctl_upload_req}, 32'd0);
        checkOutput("rst_pause_req", {31'd0, pause_req}, 32'd0);
        checkOutput("rst_ram_rd", {31'd0, ram_rd}, 32'd0);
        checkOutput("rst_ram_addr", {16'd0, ram_addr}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        reset_n = 1'b1;
        idleCycles(2);

        $display("[TB] full save through save_trigger");
        save_trigger = 1'b1;
        @(negedge clk_sys);
        save_trigger = 1'b0;
        checkOutput("save_upload_req", {31'd0, hps.ioctl_upload_req}, 32'd1);
        idleCycles(3);
        hps.ioctl_upload = 1'b1;
        hps.ioctl_index  = 8'd4;
        @(negedge clk_sys);
        checkOutput("save_pause_req", {31'd0, pause_req}, 32'd1);
        checkOutput("save_req_dropped", {31'd0, hps.ioctl_upload_req}, 32'd0);
        idleCycles(4);
        pause_ack = 1'b1;
        rd_snap = ram_rd_cnt;
        for (int i = 0; i < 256; i++) begin
            applyStimulus(25'(i), 8'(i) ^ 8'h5A);
            collectRead("save", 2);
        end
        checkOutput("save_ram_rd_count", 32'(ram_rd_cnt - rd_snap), 32'd256);

        $display("[TB] out-of-range offsets");
        rd_snap = ram_rd_cnt;
        applyStimulus(25'd256, 8'hFF);
        collectRead("oor_256", 2);
        applyStimulus(25'h1FFFFFF, 8'hFF);
        collectRead("oor_max", 2);
        @(negedge clk_sys);
        checkOutput("oor_ram_rd_count", 32'(ram_rd_cnt - rd_snap), 32'd0);

        done_snap = done_cnt;
        hps.ioctl_upload = 1'b0;
        @(negedge clk_sys);
        checkOutput("save_done_pulse", {31'd0, done}, 32'd1);
        checkOutput("save_pause_req_clear", {31'd0, pause_req}, 32'd0);
        @(negedge clk_sys);
        checkOutput("save_done_low", {31'd0, done}, 32'd0);
        checkOutput("save_done_count", 32'(done_cnt - done_snap), 32'd1);
        pause_ack = 1'b0;
        idleCycles(2);

        $display("[TB] early read before pause_ack");
        hps.ioctl_upload = 1'b1;
        hps.ioctl_index  = 8'd4;
        rd_snap = ram_rd_cnt;
        applyStimulus(25'd3, 8'h03 ^ 8'h5A);
        hi = 0;
        for (int k = 0; k < 10; k++) begin
            if (hps.ioctl_wait === 1'b1) hi = hi + 1;
            @(negedge clk_sys);
        end
        checkOutput("early_wait_hold", 32'(hi), 32'd10);
        checkOutput("early_no_ram_rd", 32'(ram_rd_cnt - rd_snap), 32'd0);
        pause_ack = 1'b1;
        collectRead("early", 4);
        checkOutput("early_ram_rd_count", 32'(ram_rd_cnt - rd_snap), 32'd1);
        hps.ioctl_upload = 1'b0;
        pause_ack = 1'b0;
        idleCycles(3);

        $display("[TB] timeout with no session");
        save_trigger = 1'b1;
        @(negedge clk_sys);
        save_trigger = 1'b0;
        n = 0;
        while (hps.ioctl_upload_req === 1'b1 && n < 200) begin
            n = n + 1;
            @(negedge clk_sys);
        end
        checkOutput("tmo_req_cycles", 32'(n), 32'd100);
        checkOutput("tmo_err_pulse", {31'd0, timeout_err}, 32'd1);
        @(negedge clk_sys);
        checkOutput("tmo_err_low", {31'd0, timeout_err}, 32'd0);
        checkOutput("tmo_pause_req", {31'd0, pause_req}, 32'd0);

        $display("[TB] foreign index session");
        hps.ioctl_upload = 1'b1;
        hps.ioctl_index  = 8'd5;
        rd_snap = ram_rd_cnt;
        hi = 0;
        for (int k = 0; k < 4; k++) begin
            hps.ioctl_rd   = 1'b1;
            hps.ioctl_addr = 25'(k);
            @(negedge clk_sys);
            hps.ioctl_rd = 1'b0;
            for (int j = 0; j < 3; j++) begin
                if (hps.ioctl_wait !== 1'b0 || pause_req !== 1'b0) hi = hi + 1;
                @(negedge clk_sys);
            end
        end
        checkOutput("foreign_wait_pause", 32'(hi), 32'd0);
        checkOutput("foreign_ram_rd_count", 32'(ram_rd_cnt - rd_snap), 32'd0);
        hps.ioctl_upload = 1'b0;
        idleCycles(2);

        $display("[TB] reset during a read");
        hps.ioctl_upload = 1'b1;
        hps.ioctl_index  = 8'd4;
        idleCycles(2);
        pause_ack = 1'b1;
        idleCycles(2);
        hps.ioctl_rd   = 1'b1;
        hps.ioctl_addr = 25'd7;
        @(negedge clk_sys);
        hps.ioctl_rd = 1'b0;
        checkOutput("mid_ram_rd", {31'd0, ram_rd}, 32'd1);
        @(negedge clk_sys);
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_wait", {31'd0, hps.ioctl_wait}, 32'd0);
        checkOutput("mid_rst_din", {24'd0, hps.ioctl_din}, 32'hFF);
        checkOutput("mid_rst_pause_req", {31'd0, pause_req}, 32'd0);
        checkOutput("mid_rst_ram_rd", {31'd0, ram_rd}, 32'd0);
        checkOutput("mid_rst_upload_req", {31'd0, hps.ioctl_upload_req}, 32'd0);
        hps.ioctl_upload = 1'b0;
        pause_ack = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        idleCycles(2);

        hps.ioctl_upload = 1'b1;
        hps.ioctl_index  = 8'd4;
        @(negedge clk_sys);
        checkOutput("post_rst_pause_req", {31'd0, pause_req}, 32'd1);
        idleCycles(2);
        pause_ack = 1'b1;
        applyStimulus(25'd10, 8'd10 ^ 8'h5A);
        collectRead("post_rst_10", 2);
        applyStimulus(25'd255, 8'd255 ^ 8'h5A);
        collectRead("post_rst_255", 2);
        done_snap = done_cnt;
        hps.ioctl_upload = 1'b0;
        pause_ack = 1'b0;
        idleCycles(2);
        checkOutput("post_rst_done_count", 32'(done_cnt - done_snap), 32'd1);
        checkOutput("post_rst_pause_clear", {31'd0, pause_req}, 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
